// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: per-channel LED mode controller (off / on / blink / PWM)
// with a global chase override and registered outputs.
// Optional build macro LED_FADE_EN: mode 11 becomes a breathing ramp
// whose ceiling is the channel's programmed duty.
module led_mode_ctrl #(
    parameter int N_LED       = 3,
    parameter int PRESCALE    = 50000,
    parameter int BLINK_TICKS = 250,
    parameter int PWM_BITS    = 4
) (
    input  logic                led_clk,
    input  logic                led_rst_n,
    input  logic                wr_en,
    input  logic [3:0]          wr_sel,
    input  logic [1:0]          wr_mode,
    input  logic [PWM_BITS-1:0] wr_duty,
    input  logic                chase_en,
    output logic                wr_err,
    output logic                tick,
    output logic [N_LED-1:0]    led
);

    localparam int PW = $clog2(PRESCALE);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int CW = (N_LED > 1) ? $clog2(N_LED) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
    localparam logic [CW-1:0] CHASE_LAST = CW'(N_LED - 1);
    localparam logic [4:0]    N_LED_W    = 5'(N_LED);

    logic [PW-1:0]       presc_cnt_reg;
    logic [BW-1:0]       blink_cnt_reg;
    logic                blink_phase_reg;
    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic [CW-1:0]       chase_pos_reg;
    logic                wr_err_reg;
    logic [N_LED-1:0]    led_reg;
    logic [N_LED-1:0]    led_next;

    logic tick_now;
    logic blink_wrap;
    logic wr_bad;

    assign tick_now   = (presc_cnt_reg == PRESC_LAST);
    assign blink_wrap = tick_now && (blink_cnt_reg == BLINK_LAST);
    assign wr_bad     = wr_en && ({1'b0, wr_sel} >= N_LED_W);

    assign tick   = tick_now;
    assign wr_err = wr_err_reg;
    assign led    = led_reg;

    // Shared timebase: prescaler, blink counter/phase, PWM counter, chase position
    always_ff @(posedge led_clk or negedge led_rst_n) begin
        if (!led_rst_n) begin
            presc_cnt_reg   <= '0;
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            pwm_cnt_reg     <= '0;
            chase_pos_reg   <= '0;
        end else begin
            presc_cnt_reg <= tick_now ? '0 : presc_cnt_reg + 1'b1;
            pwm_cnt_reg   <= pwm_cnt_reg + 1'b1;
            if (tick_now) begin
                blink_cnt_reg <= blink_wrap ? '0 : blink_cnt_reg + 1'b1;
            end
            if (blink_wrap) begin
                blink_phase_reg <= ~blink_phase_reg;
            end
            // Chase only advances while it is being displayed
            if (blink_wrap && chase_en) begin
                chase_pos_reg <= (chase_pos_reg == CHASE_LAST) ? '0 : chase_pos_reg + 1'b1;
            end
        end
    end

    // Error pulse for writes aimed past the last channel
    always_ff @(posedge led_clk or negedge led_rst_n) begin
        if (!led_rst_n) begin
            wr_err_reg <= 1'b0;
        end else begin
            wr_err_reg <= wr_bad;
        end
    end

    generate
        for (genvar gi = 0; gi < N_LED; gi++) begin : g_chan
            logic [1:0]          mode_reg;
            logic [PWM_BITS-1:0] duty_reg;
            logic [PWM_BITS-1:0] duty_eff;
            logic                chan_val;
            logic                wr_hit;

            assign wr_hit = wr_en && (wr_sel == 4'(gi));

            // Channel configuration written by the control FSM
            always_ff @(posedge led_clk or negedge led_rst_n) begin
                if (!led_rst_n) begin
                    mode_reg <= 2'b00;
                    duty_reg <= '0;
                end else if (wr_hit) begin
                    mode_reg <= wr_mode;
                    duty_reg <= wr_duty;
                end
            end

`ifdef LED_FADE_EN
            logic [PWM_BITS-1:0] ramp_reg;
            logic                ramp_up_reg;

            // Breathing ramp: triangle between 0 and duty_reg, one step per tick
            always_ff @(posedge led_clk or negedge led_rst_n) begin
                if (!led_rst_n) begin
                    ramp_reg    <= '0;
                    ramp_up_reg <= 1'b1;
                end else if (wr_hit && (wr_mode == 2'b11)) begin
                    ramp_reg    <= '0;
                    ramp_up_reg <= 1'b1;
                end else if (tick_now) begin
                    if (ramp_up_reg) begin
                        if (ramp_reg >= duty_reg) begin
                            ramp_up_reg <= 1'b0;
                            if (ramp_reg != '0) begin
                                ramp_reg <= ramp_reg - 1'b1;
                            end
                        end else begin
                            ramp_reg <= ramp_reg + 1'b1;
                        end
                    end else begin
                        if (ramp_reg == '0) begin
                            ramp_up_reg <= 1'b1;
                            if (duty_reg != '0) begin
                                ramp_reg <= ramp_reg + 1'b1;
                            end
                        end else begin
                            ramp_reg <= ramp_reg - 1'b1;
                        end
                    end
                end
            end

            assign duty_eff = ramp_reg;
`else
            assign duty_eff = duty_reg;
`endif

            // Per-channel drive value selected by mode
            always_comb begin
                chan_val = 1'b0;
                case (mode_reg)
                    2'b01:   chan_val = 1'b1;
                    2'b10:   chan_val = blink_phase_reg;
                    2'b11:   chan_val = (pwm_cnt_reg < duty_eff);
                    default: chan_val = 1'b0;
                endcase
            end

            // Chase override replaces the mode output but leaves configuration intact
            assign led_next[gi] = chase_en ? (chase_pos_reg == CW'(gi)) : chan_val;
        end
    endgenerate

    // Registered LED drive
    always_ff @(posedge led_clk or negedge led_rst_n) begin
        if (!led_rst_n) begin
            led_reg <= '0;
        end else begin
            led_reg <= led_next;
        end
    end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Testbench for led_mode_ctrl: directed scenarios plus randomized traffic,
// checked against a cycle-count based reference model.
module tb_led_mode_ctrl;

    localparam int N  = 3;
    localparam int PS = 4;
    localparam int BT = 2;
    localparam int PB = 2;

    logic          led_clk   = 1'b0;
    logic          led_rst_n = 1'b0;
    logic          wr_en     = 1'b0;
    logic [3:0]    wr_sel    = '0;
    logic [1:0]    wr_mode   = '0;
    logic [PB-1:0] wr_duty   = '0;
    logic          chase_en  = 1'b0;
    logic          wr_err;
    logic          tick;
    logic [N-1:0]  led;

    led_mode_ctrl #(
        .N_LED       (N),
        .PRESCALE    (PS),
        .BLINK_TICKS (BT),
        .PWM_BITS    (PB)
    ) dut (
        .led_clk   (led_clk),
        .led_rst_n (led_rst_n),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_mode   (wr_mode),
        .wr_duty   (wr_duty),
        .chase_en  (chase_en),
        .wr_err    (wr_err),
        .tick      (tick),
        .led       (led)
    );

    always #5 led_clk = ~led_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: all timing derived from edges counted since reset release
    int           m_n;
    int           m_mode [N];
    int           m_duty [N];
    int           m_chase;
    logic [N-1:0] exp_led;
    logic         exp_err;
    logic         exp_tick;

    task automatic model_reset();
        m_n = 0;
        for (int i = 0; i < N; i++) begin
            m_mode[i] = 0;
            m_duty[i] = 0;
        end
        m_chase  = 0;
        exp_led  = '0;
        exp_err  = 1'b0;
        exp_tick = 1'b0;
    endtask

    // Advance one clock: predict outputs after the edge, update model, sample at edge+1
    task automatic step();
        int           pwm_now;
        bit           phase;
        logic [N-1:0] nl;
        pwm_now = m_n % (1 << PB);
        phase   = ((m_n / (PS * BT)) % 2) == 1;
        nl      = '0;
        for (int i = 0; i < N; i++) begin
            if (chase_en) nl[i] = (i == m_chase);
            else begin
                case (m_mode[i])
                    1:       nl[i] = 1'b1;
                    2:       nl[i] = phase;
                    3:       nl[i] = (pwm_now < m_duty[i]);
                    default: nl[i] = 1'b0;
                endcase
            end
        end
        exp_led = nl;
        exp_err = wr_en && (int'(wr_sel) >= N);
        if (wr_en) begin
            $display("wr t=%0t sel=%0d mode=%0d duty=%0d chase=%0b", $time, wr_sel, wr_mode, wr_duty, chase_en);
            if (int'(wr_sel) < N) begin
                m_mode[wr_sel] = int'(wr_mode);
                m_duty[wr_sel] = int'(wr_duty);
            end
        end
        m_n++;
        if (chase_en && (m_n % (PS * BT)) == 0) m_chase = (m_chase + 1) % N;
        exp_tick = (m_n % PS) == (PS - 1);
        @(posedge led_clk);
        #1;
    endtask

    task automatic do_reset();
        led_rst_n = 1'b0;
        wr_en     = 1'b0;
        chase_en  = 1'b0;
        repeat (3) @(posedge led_clk);
        @(negedge led_clk);
        led_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic write(input int sel, input int mode, input int duty);
        wr_en   = 1'b1;
        wr_sel  = 4'(sel);
        wr_mode = 2'(mode);
        wr_duty = PB'(duty);
        step();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (led !== 3'b000 || wr_err !== 1'b0 || tick !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async led=%b err=%b tick=%b need 000/0/0", led, wr_err, tick);
        end
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            step();
            n_cmp++;
            if (tick !== ((c % 4) == 3) || led !== 3'b000 || wr_err !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_tick cyc=%0d tick=%b need %b led=%b err=%b", c, tick, (c % 4) == 3, led, wr_err);
            end
        end
    endtask

    task automatic test_on_off();
        write(1, 1, 0);
        n_cmp++;
        if (led !== 3'b000) begin
            n_bad++;
            $display("FAIL on_latency led=%b need 000", led);
        end
        step();
        n_cmp++;
        if (led !== 3'b010) begin
            n_bad++;
            $display("FAIL on_value led=%b need 010", led);
        end
        write(1, 0, 0);
        step();
        n_cmp++;
        if (led !== 3'b000) begin
            n_bad++;
            $display("FAIL off_value led=%b need 000", led);
        end
    endtask

    task automatic test_blink();
        write(0, 2, 0);
        for (int c = 0; c < 32; c++) begin
            step();
            n_cmp++;
            if (led !== exp_led) begin
                n_bad++;
                $display("FAIL blink cyc=%0d led=%b need %b", c, led, exp_led);
            end
        end
    endtask

    task automatic test_pwm();
        write(0, 0, 0);
        write(2, 3, 2);
        for (int c = 0; c < 16; c++) begin
            step();
            n_cmp++;
            if (led !== exp_led) begin
                n_bad++;
                $display("FAIL pwm_duty2 cyc=%0d led=%b need %b", c, led, exp_led);
            end
        end
        write(2, 3, 0);
        step();
        for (int c = 0; c < 8; c++) begin
            step();
            n_cmp++;
            if (led[2] !== 1'b0) begin
                n_bad++;
                $display("FAIL pwm_duty0 cyc=%0d led2=%b need 0", c, led[2]);
            end
        end
    endtask

    task automatic test_wr_err();
        write(1, 1, 0);
        write(5, 2, 3);
        n_cmp++;
        if (wr_err !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_err_pulse err=%b need 1", wr_err);
        end
        step();
        n_cmp++;
        if (wr_err !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_err_clear err=%b need 0", wr_err);
        end
        for (int c = 0; c < 8; c++) begin
            step();
            n_cmp++;
            if (led !== exp_led || wr_err !== 1'b0) begin
                n_bad++;
                $display("FAIL wr_err_nochange cyc=%0d led=%b need %b err=%b", c, led, exp_led, wr_err);
            end
        end
    endtask

    task automatic test_chase();
        write(0, 1, 0);
        write(1, 0, 0);
        write(2, 0, 0);
        chase_en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            n_cmp++;
            if (led !== exp_led) begin
                n_bad++;
                $display("FAIL chase cyc=%0d led=%b need %b", c, led, exp_led);
            end
            if (c == 20) begin
                wr_en = 1'b1; wr_sel = 4'd2; wr_mode = 2'd1; wr_duty = '0;
            end else begin
                wr_en = 1'b0;
            end
        end
        chase_en = 1'b0;
        step();
        n_cmp++;
        if (led !== 3'b101) begin
            n_bad++;
            $display("FAIL chase_exit led=%b need 101", led);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            wr_en   = ($urandom % 3) == 0;
            wr_sel  = 4'($urandom % 6);
            wr_mode = 2'($urandom);
            wr_duty = PB'($urandom);
            if (($urandom % 25) == 0) chase_en = ~chase_en;
            step();
            n_cmp++;
            if (led !== exp_led || wr_err !== exp_err || tick !== exp_tick) begin
                n_bad++;
                $display("FAIL random cyc=%0d led=%b/%b err=%b/%b tick=%b/%b (got/need)",
                         c, led, exp_led, wr_err, exp_err, tick, exp_tick);
            end
        end
        wr_en    = 1'b0;
        chase_en = 1'b0;
    endtask

    task automatic test_async_reset();
        write(0, 0, 0);
        write(1, 1, 0);
        write(2, 0, 0);
        step();
        n_cmp++;
        if (led !== 3'b010) begin
            n_bad++;
            $display("FAIL areset_pre led=%b need 010", led);
        end
        #2;
        led_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (led !== 3'b000 || wr_err !== 1'b0) begin
            n_bad++;
            $display("FAIL areset_now led=%b err=%b need 000/0", led, wr_err);
        end
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            step();
            n_cmp++;
            if (tick !== ((c % 4) == 3) || led !== 3'b000) begin
                n_bad++;
                $display("FAIL areset_restart cyc=%0d tick=%b led=%b", c, tick, led);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_on_off();
        test_blink();
        test_pwm();
        test_wr_err();
        test_chase();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
